// File: rtl/tl_pkg.sv
// Shared TileLink definitions: size field width, arbiter state type and the
// beats-per-message helper also used by the burst tracker.
package tl_pkg;

  localparam int TL_SIZE_WIDTH = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Messages without data, or no larger than one channel beat, take a single beat.
  function automatic logic [15:0] tl_beats(
    input logic [TL_SIZE_WIDTH-1:0] size,
    input logic                     has_data,
    input int                       non_burst_size
  );
    int sz;
    sz = int'(size);
    if (has_data && (sz > non_burst_size)) begin
      return 16'd1 << (sz - non_burst_size);
    end
    return 16'd1;
  endfunction

endpackage

// File: rtl/tl_rr_grant.sv
// One-hot grant: the first requesting index after ptr_i, searched cyclically.
// A constant pointer of NumReq-1 turns it into lowest-index-wins priority.
module tl_rr_grant #(
  parameter int NumReq = 3,
  localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = IdxW'((int'(ptr_i) + k) % NumReq);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_beat_arbiter.sv
// Beat-level arbiter sharing one TileLink channel; multi-beat messages hold the
// grant until their last beat. Define TL_BEAT_ARBITER_ROUND_ROBIN_EN for round-robin.
module tl_beat_arbiter
  import tl_pkg::*;
#(
  parameter int NumReq       = 3,
  parameter int DataWidth    = 64,
  parameter int MaxSize      = 6,
  parameter int PayloadWidth = 128
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][TL_SIZE_WIDTH-1:0]  req_size_i,
  input  logic [NumReq-1:0]                     req_has_data_i,
  input  logic [NumReq-1:0][PayloadWidth-1:0]   req_payload_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [PayloadWidth-1:0]               out_payload_o,
  output logic [NumReq-1:0]                     out_sel_o,
  output logic                                  out_first_o,
  output logic                                  out_last_o
);

  localparam int NonBurstSize = $clog2(DataWidth / 8);
  localparam int CntW = ((MaxSize - NonBurstSize) > 1) ? (MaxSize - NonBurstSize) : 1;
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] sel_q, sel_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NumReq-1:0]        grant;
  logic [IdxW-1:0]          grant_ptr;
  logic [NumReq-1:0]        sel;
  logic [PayloadWidth-1:0]  sel_payload;
  logic [TL_SIZE_WIDTH-1:0] sel_size;
  logic                     sel_has_data;
  logic [15:0]              msg_beats;
  logic                     multi_beat;
  logic                     handshake;

  tl_rr_grant #(
    .NumReq (NumReq)
  ) u_grant (
    .req_i (req_valid_i),
    .ptr_i (grant_ptr),
    .gnt_o (grant)
  );

`ifdef TL_BEAT_ARBITER_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake && (state_q == ARB_IDLE)) begin
      for (int i = 0; i < NumReq; i++) begin
        if (sel[i]) ptr_d = IdxW'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= IdxW'(NumReq - 1);
    else       ptr_q <= ptr_d;
  end

  assign grant_ptr = ptr_q;
`else
  assign grant_ptr = IdxW'(NumReq - 1);
`endif

  // Mid-burst the registered owner keeps the channel; reset forces no owner.
  always_comb begin
    sel = grant;
    if (state_q == ARB_LOCKED) sel = sel_q;
    if (rst_i) sel = '0;
  end

  always_comb begin
    sel_payload  = '0;
    sel_size     = '0;
    sel_has_data = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      sel_payload  = sel_payload | (req_payload_i[i] & {PayloadWidth{sel[i]}});
      sel_size     = sel_size | (req_size_i[i] & {TL_SIZE_WIDTH{sel[i]}});
      sel_has_data = sel_has_data | (req_has_data_i[i] & sel[i]);
    end
  end

  assign msg_beats  = tl_beats(sel_size, sel_has_data, NonBurstSize);
  assign multi_beat = (msg_beats != 16'd1);
  assign handshake  = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (handshake) begin
      if (state_q == ARB_IDLE) begin
        if (multi_beat) begin
          state_d = ARB_LOCKED;
          sel_d   = sel;
          cnt_d   = CntW'(msg_beats - 16'd1);
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_sel_o     = sel;
  assign out_valid_o   = |(req_valid_i & sel);
  assign req_ready_o   = sel & {NumReq{out_ready_i}};
  assign out_payload_o = sel_payload;
  assign out_first_o   = (state_q == ARB_IDLE);
  assign out_last_o    = (state_q == ARB_IDLE) ? !multi_beat : (cnt_q == CntW'(1));

endmodule

// File: tb/tb_tl_beat_arbiter.sv
// Directed self-checking bench for tl_beat_arbiter with NumReq=3, DataWidth=64.
// Each scenario task drives beats and compares outputs against hand-derived values.
module tb_tl_beat_arbiter;
  import tl_pkg::*;

  localparam int NumReq = 3;
  localparam int PW     = 128;

  logic                                 clk_i;
  logic                                 rst_i;
  logic [NumReq-1:0]                    req_valid_i;
  logic [NumReq-1:0]                    req_ready_o;
  logic [NumReq-1:0][TL_SIZE_WIDTH-1:0] req_size_i;
  logic [NumReq-1:0]                    req_has_data_i;
  logic [NumReq-1:0][PW-1:0]            req_payload_i;
  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [PW-1:0]                        out_payload_o;
  logic [NumReq-1:0]                    out_sel_o;
  logic                                 out_first_o;
  logic                                 out_last_o;

  int errors = 0;
  int checks = 0;

  tl_beat_arbiter #(
    .NumReq(NumReq), .DataWidth(64), .MaxSize(6), .PayloadWidth(PW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_size_i(req_size_i), .req_has_data_i(req_has_data_i),
    .req_payload_i(req_payload_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_payload_o(out_payload_o), .out_sel_o(out_sel_o),
    .out_first_o(out_first_o), .out_last_o(out_last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [3:0] sz,
                         input logic hd, input logic [PW-1:0] pl);
    req_valid_i[r]    = v;
    req_size_i[r]     = sz;
    req_has_data_i[r] = hd;
    req_payload_i[r]  = pl;
  endtask

  task automatic clear_all();
    req_valid_i    = '0;
    req_size_i     = '0;
    req_has_data_i = '0;
    req_payload_i  = '0;
  endtask

  function automatic logic [PW-1:0] beat_pl(input int r, input int b);
    return {64'hC0DE_0000_0000_0000 + 64'(r), 64'(b)};
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    set_req(0, 1'b1, 4'd3, 1'b1, beat_pl(0, 0));
    set_req(1, 1'b1, 4'd6, 1'b1, beat_pl(1, 0));
    set_req(2, 1'b1, 4'd3, 1'b1, beat_pl(2, 0));
    tick();
    #1;
    checks++;
    if (req_ready_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready actual=%b expected=000", req_ready_o); end
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual=%b expected=0", out_valid_o); end
    checks++;
    if (out_sel_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_sel actual=%b expected=000", out_sel_o); end
    clear_all();
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (out_first_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_first actual=%b expected=1", out_first_o); end
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_valid actual=%b expected=0", out_valid_o); end
  endtask

  task automatic test_single_beats();
    tick();
    set_req(0, 1'b1, 4'd3, 1'b1, beat_pl(0, 1));
    set_req(2, 1'b1, 4'd3, 1'b1, beat_pl(2, 1));
    #1;
    checks++;
    if (out_sel_o !== 3'b001 || out_payload_o !== beat_pl(0, 1) || req_ready_o !== 3'b001)
      begin errors++; $display("[TB] FAIL single_beat0 sel=%b ready=%b payload=%h expected sel=001", out_sel_o, req_ready_o, out_payload_o); end
    checks++;
    if (out_first_o !== 1'b1 || out_last_o !== 1'b1)
      begin errors++; $display("[TB] FAIL single_beat0_flags first=%b last=%b expected 1 1", out_first_o, out_last_o); end
    tick();
    req_valid_i[0] = 1'b0;
    #1;
    checks++;
    if (out_sel_o !== 3'b100 || out_payload_o !== beat_pl(2, 1) || out_valid_o !== 1'b1)
      begin errors++; $display("[TB] FAIL single_beat2 sel=%b valid=%b payload=%h expected sel=100", out_sel_o, out_valid_o, out_payload_o); end
    checks++;
    if (out_first_o !== 1'b1 || out_last_o !== 1'b1)
      begin errors++; $display("[TB] FAIL single_beat2_flags first=%b last=%b expected 1 1", out_first_o, out_last_o); end
    tick();
    clear_all();
  endtask

  task automatic test_burst();
    tick();
    for (int b = 1; b <= 8; b++) begin
      set_req(1, 1'b1, 4'd6, 1'b1, beat_pl(1, b));
      if (b == 2) set_req(0, 1'b1, 4'd3, 1'b1, beat_pl(0, 9));
      #1;
      checks++;
      if (out_sel_o !== 3'b010 || out_valid_o !== 1'b1 || out_payload_o !== beat_pl(1, b))
        begin errors++; $display("[TB] FAIL burst_beat%0d sel=%b valid=%b payload=%h expected sel=010", b, out_sel_o, out_valid_o, out_payload_o); end
      checks++;
      if (out_first_o !== (b == 1) || out_last_o !== (b == 8))
        begin errors++; $display("[TB] FAIL burst_flags%0d first=%b last=%b expected %b %b", b, out_first_o, out_last_o, b == 1, b == 8); end
      tick();
    end
    req_valid_i[1] = 1'b0;
    #1;
    checks++;
    if (out_sel_o !== 3'b001 || out_first_o !== 1'b1)
      begin errors++; $display("[TB] FAIL burst_release sel=%b first=%b expected sel=001 first=1", out_sel_o, out_first_o); end
    tick();
    clear_all();
  endtask

  task automatic test_stall();
    tick();
    for (int b = 1; b <= 3; b++) begin
      set_req(1, 1'b1, 4'd6, 1'b1, beat_pl(1, b));
      tick();
    end
    req_valid_i[1] = 1'b0;
    set_req(0, 1'b1, 4'd3, 1'b1, beat_pl(0, 5));
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (out_valid_o !== 1'b0 || out_sel_o !== 3'b010 || req_ready_o[0] !== 1'b0 || out_first_o !== 1'b0)
        begin errors++; $display("[TB] FAIL stall_gap%0d valid=%b sel=%b ready=%b first=%b expected 0 010", c, out_valid_o, out_sel_o, req_ready_o, out_first_o); end
      tick();
    end
    for (int b = 4; b <= 8; b++) begin
      set_req(1, 1'b1, 4'd6, 1'b1, beat_pl(1, b));
      if (b == 5) begin
        out_ready_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_sel_o !== 3'b010 || out_last_o !== 1'b0 || req_ready_o !== 3'b000)
          begin errors++; $display("[TB] FAIL backpressure valid=%b sel=%b last=%b ready=%b", out_valid_o, out_sel_o, out_last_o, req_ready_o); end
        tick();
        out_ready_i = 1'b1;
      end
      #1;
      checks++;
      if (out_sel_o !== 3'b010 || out_payload_o !== beat_pl(1, b) || out_last_o !== (b == 8))
        begin errors++; $display("[TB] FAIL stall_beat%0d sel=%b last=%b payload=%h expected sel=010 last=%b", b, out_sel_o, out_last_o, out_payload_o, b == 8); end
      tick();
    end
    req_valid_i[1] = 1'b0;
    #1;
    checks++;
    if (out_sel_o !== 3'b001 || out_first_o !== 1'b1)
      begin errors++; $display("[TB] FAIL stall_release sel=%b first=%b expected 001 1", out_sel_o, out_first_o); end
    tick();
    clear_all();
  endtask

  task automatic test_no_data();
    tick();
    set_req(1, 1'b1, 4'd6, 1'b0, beat_pl(1, 0));
    #1;
    checks++;
    if (out_sel_o !== 3'b010 || out_first_o !== 1'b1 || out_last_o !== 1'b1)
      begin errors++; $display("[TB] FAIL nodata_beat sel=%b first=%b last=%b expected 010 1 1", out_sel_o, out_first_o, out_last_o); end
    tick();
    req_valid_i[1] = 1'b0;
    set_req(0, 1'b1, 4'd3, 1'b1, beat_pl(0, 2));
    #1;
    checks++;
    if (out_sel_o !== 3'b001 || out_first_o !== 1'b1)
      begin errors++; $display("[TB] FAIL nodata_no_lock sel=%b first=%b expected 001 1", out_sel_o, out_first_o); end
    tick();
    clear_all();
  endtask

  task automatic test_reset_mid_burst();
    tick();
    for (int b = 1; b <= 4; b++) begin
      set_req(1, 1'b1, 4'd6, 1'b1, beat_pl(1, b));
      tick();
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || out_sel_o !== 3'b000 || req_ready_o !== 3'b000)
      begin errors++; $display("[TB] FAIL midreset_outputs valid=%b sel=%b ready=%b expected 0 000 000", out_valid_o, out_sel_o, req_ready_o); end
    tick();
    rst_i = 1'b0;
    set_req(0, 1'b1, 4'd3, 1'b1, beat_pl(0, 7));
    set_req(1, 1'b1, 4'd6, 1'b1, beat_pl(1, 5));
    #1;
    checks++;
    if (out_sel_o !== 3'b001 || out_first_o !== 1'b1 || out_last_o !== 1'b1)
      begin errors++; $display("[TB] FAIL midreset_regrant sel=%b first=%b last=%b expected 001 1 1", out_sel_o, out_first_o, out_last_o); end
    tick();
    clear_all();
    tick();
  endtask

`ifndef TL_BEAT_ARBITER_ROUND_ROBIN_EN
  task automatic test_fixed_priority();
    for (int r = 0; r < NumReq; r++) set_req(r, 1'b1, 4'd3, 1'b1, beat_pl(r, 3));
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_sel_o !== 3'b001 || out_payload_o !== beat_pl(0, 3))
        begin errors++; $display("[TB] FAIL fixed_prio%0d sel=%b expected 001", c, out_sel_o); end
      tick();
    end
    clear_all();
  endtask
`else
  task automatic test_round_robin();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int r = 0; r < NumReq; r++) set_req(r, 1'b1, 4'd3, 1'b1, beat_pl(r, 3));
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_sel_o !== (3'b001 << (c % 3)))
        begin errors++; $display("[TB] FAIL rr_grant%0d sel=%b expected %b", c, out_sel_o, 3'b001 << (c % 3)); end
      tick();
    end
    clear_all();
  endtask
`endif

  initial begin
    rst_i       = 1'b1;
    out_ready_i = 1'b1;
    clear_all();
    test_reset();
    test_single_beats();
    test_burst();
    test_stall();
    test_no_data();
    test_reset_mid_burst();
`ifndef TL_BEAT_ARBITER_ROUND_ROBIN_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_beat_arbiter.md
TL_BEAT_ARBITER -- requirements
Module: tl_beat_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 3: number of requesters sharing one TileLink channel.
REQ-002 SHALL have parameter DataWidth, default 64: channel data width in bits; NonBurstSize = log2(DataWidth/8).
REQ-003 SHALL have parameter MaxSize, default 6: largest legal log2 transfer size in bytes.
REQ-004 SHALL have parameter PayloadWidth, default 128: width of the opaque beat payload that is forwarded.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid_i, input, NumReq: per-requester beat valid.
REQ-008 SHALL have port req_ready_o, output, NumReq: per-requester beat accept.
REQ-009 SHALL have port req_size_i, input, NumReq x TL_SIZE_WIDTH: log2 message size of the current beat.
REQ-010 SHALL have port req_has_data_i, input, NumReq: set when the message carries data, making it multi-beat when size > NonBurstSize.
REQ-011 SHALL have port req_payload_i, input, NumReq x PayloadWidth: beat contents.
REQ-012 SHALL have port out_valid_o, output, 1, and port out_ready_i, input, 1: the shared channel handshake.
REQ-013 SHALL have port out_payload_o, output, PayloadWidth: payload of the selected requester.
REQ-014 SHALL have port out_sel_o, output, NumReq: one-hot index of the selected requester, all-zero when none is selected.
REQ-015 SHALL have ports out_first_o and out_last_o, outputs, 1 each: the current beat is the first or last beat of its message.

Function
REQ-016 Beats per message SHALL be 2^(size-NonBurstSize) when has_data is set and size > NonBurstSize, and 1 otherwise.
REQ-017 Arbitration SHALL be combinational with zero added latency: out_valid_o = req_valid_i[sel], out_payload_o = req_payload_i[sel], and req_ready_o[i] = out_ready_i & sel[i].
REQ-018 Arbitration state SHALL be IDLE (unlocked) or LOCKED (mid-burst).
REQ-019 In IDLE, sel SHALL be the arbiter grant over req_valid_i; when no requester is valid, sel SHALL be zero and out_valid_o SHALL be 0.
REQ-020 A first-beat handshake of a message longer than one beat SHALL move the block IDLE -> LOCKED, register sel, and load the beat counter with beats-1.
REQ-021 In LOCKED, sel SHALL be the registered sel, regardless of other valids.
REQ-022 In LOCKED, each handshake SHALL decrement the counter, and the handshake at counter==1 SHALL return the block to IDLE.
REQ-023 A single-beat message SHALL never enter LOCKED.
REQ-024 out_first_o SHALL be 1 exactly when the block is in IDLE; out_last_o SHALL be 1 when the message is single-beat, or when the block is LOCKED with counter==1.
REQ-025 If the locked requester deasserts valid mid-burst, out_valid_o SHALL be 0, the block SHALL stay LOCKED and the counter SHALL hold.
REQ-026 out_valid_o with out_ready_i low SHALL cause no state change; grant and payload SHALL stay stable while out_valid_o is held.
REQ-027 The beat counter SHALL be MaxSize-NonBurstSize bits wide, or at least 1 bit; a size above MaxSize is illegal and its behaviour is undefined.

Reset
REQ-028 With rst_i high at a clock edge, the block SHALL go to IDLE, clear the counter, and set the round-robin pointer to NumReq-1 so requester 0 has highest priority next.
REQ-029 While rst_i is high, req_ready_o SHALL be 0, out_valid_o SHALL be 0 and out_sel_o SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; no partial-burst state SHALL survive.

Configuration
REQ-031 With macro TL_BEAT_ARBITER_ROUND_ROBIN_EN defined, the grant SHALL be the first valid index after the pointer, cyclically.
REQ-032 With that macro defined, the pointer SHALL update to the granted index on every IDLE first-beat handshake.
REQ-033 Without the macro, the grant SHALL be fixed-priority to the lowest valid index, and no pointer register SHALL exist.

Structure
REQ-034 TL_SIZE_WIDTH and the beats-per-message computation SHALL come from tl_pkg, shared with the burst tracker.
REQ-035 The grant logic SHALL be one sub-module, tl_rr_grant (request vector and pointer in, one-hot grant out); the lock and counter logic stays in tl_beat_arbiter.

Verification (DataWidth=64, NumReq=3)
REQ-036 Requesters 0 and 2 valid, both size 3 with data, out_ready_i=1 -> grant 0 then 2 on consecutive cycles, out_first_o=out_last_o=1 on both beats.
REQ-037 Requester 1 sends size 6 with data while 0 becomes valid on the 2nd beat -> 8 beats from requester 1 uninterrupted, out_last_o only on beat 8, requester 0 granted on the next cycle.
REQ-038 Requester 1 drops valid for 2 cycles after beat 3 of an 8-beat burst -> out_valid_o=0 for those cycles, LOCKED held, requester 0 never granted, 5 more beats complete the burst.
REQ-039 Size 6 without data -> single beat, no lock, out_last_o=1.
REQ-040 rst_i pulsed after beat 4 of an 8-beat burst -> IDLE next cycle, and with 0 and 1 valid, requester 0 is granted.
REQ-041 Without the macro, all 3 requesters continuously valid with single beats -> requester 0 granted every cycle.
